// File: rtl/shift_counter_multi.sv
// WIDTH-bit ring / Johnson / bounce shift pattern generator with position index and wrap pulse.
// Optional pattern checker with sticky err output is built when SHIFT_COUNTER_MULTI_ERRCHK_EN is defined.
module shift_counter_multi #(
  parameter int WIDTH = 8,
  parameter int PW    = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] count,
  output logic [PW-1:0]    pos,
`ifdef SHIFT_COUNTER_MULTI_ERRCHK_EN
  output logic             err,
`endif
  output logic             wrap
);

  localparam logic [1:0]    M_RING   = 2'b00;
  localparam logic [1:0]    M_JOHN   = 2'b01;
  localparam logic [1:0]    M_BOUNCE = 2'b10;
  localparam logic [PW-1:0] LAST_R   = PW'(WIDTH-1);
  localparam logic [PW-1:0] LAST_J   = PW'(2*WIDTH-1);

  logic [1:0]       mode_q, mode_d, mode_in;
  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    pos_q, pos_d;
  logic             wrap_q, wrap_d;
  logic             bdn_q, bdn_d;

  function automatic logic [WIDTH-1:0] seed(input logic [1:0] m);
    return (m == M_JOHN) ? '0 : WIDTH'(1);
  endfunction

`ifdef SHIFT_COUNTER_MULTI_ERRCHK_EN
  logic err_q, err_d, legal;

  // Johnson patterns allow at most one edge between adjacent bits (wrap-around pair excluded).
  function automatic logic pattern_ok(input logic [1:0] m, input logic [WIDTH-1:0] v);
    int n;
    n = 0;
    if (m == M_JOHN) begin
      for (int i = 0; i < WIDTH-1; i++) n = n + int'(v[i] != v[i+1]);
      return n <= 1;
    end
    for (int i = 0; i < WIDTH; i++) n = n + int'(v[i]);
    return n == 1;
  endfunction

  assign legal = pattern_ok(mode_q, count_q);
  assign err   = err_q;
`endif

  assign mode_in = (mode == 2'b11) ? M_RING : mode;

  always_comb begin
    mode_d  = mode_q;
    count_d = count_q;
    pos_d   = pos_q;
    wrap_d  = 1'b0;
    bdn_d   = bdn_q;
`ifdef SHIFT_COUNTER_MULTI_ERRCHK_EN
    err_d   = err_q | ~legal;
`endif
    if (mode_in != mode_q) begin
      mode_d  = mode_in;
      count_d = seed(mode_in);
      pos_d   = '0;
      bdn_d   = 1'b0;
    end
`ifdef SHIFT_COUNTER_MULTI_ERRCHK_EN
    else if (!legal) begin
      count_d = seed(mode_q);
      pos_d   = '0;
      bdn_d   = 1'b0;
    end
`endif
    else if (en) begin
      case (mode_q)
        M_JOHN: begin
          if (!dir) begin
            count_d = {count_q[WIDTH-2:0], ~count_q[WIDTH-1]};
            pos_d   = (pos_q == LAST_J) ? '0 : pos_q + PW'(1);
          end else begin
            count_d = {~count_q[0], count_q[WIDTH-1:1]};
            pos_d   = (pos_q == '0) ? LAST_J : pos_q - PW'(1);
          end
        end
        M_BOUNCE: begin
          // Direction flips on arrival at either end, so each end is visited once per period.
          if (!bdn_q) begin
            count_d = {count_q[WIDTH-2:0], 1'b0};
            pos_d   = pos_q + PW'(1);
            if (pos_d == LAST_R) bdn_d = 1'b1;
          end else begin
            count_d = {1'b0, count_q[WIDTH-1:1]};
            pos_d   = pos_q - PW'(1);
            if (pos_d == '0) bdn_d = 1'b0;
          end
        end
        default: begin
          if (!dir) begin
            count_d = {count_q[WIDTH-2:0], count_q[WIDTH-1]};
            pos_d   = (pos_q == LAST_R) ? '0 : pos_q + PW'(1);
          end else begin
            count_d = {count_q[0], count_q[WIDTH-1:1]};
            pos_d   = (pos_q == '0) ? LAST_R : pos_q - PW'(1);
          end
        end
      endcase
      wrap_d = (pos_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q  <= mode_in;
      count_q <= seed(mode_in);
      pos_q   <= '0;
      wrap_q  <= 1'b0;
      bdn_q   <= 1'b0;
`ifdef SHIFT_COUNTER_MULTI_ERRCHK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      mode_q  <= mode_d;
      count_q <= count_d;
      pos_q   <= pos_d;
      wrap_q  <= wrap_d;
      bdn_q   <= bdn_d;
`ifdef SHIFT_COUNTER_MULTI_ERRCHK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign count = count_q;
  assign pos   = pos_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_shift_counter_multi.sv
// Directed bench for shift_counter_multi (WIDTH=8): vector table plus bounce and checker sequences.
module tb_shift_counter_multi;

  logic       clk, reset, en, dir;
  logic [1:0] mode;
  logic [7:0] count;
  logic [3:0] pos;
  logic       wrap;
`ifdef SHIFT_COUNTER_MULTI_ERRCHK_EN
  logic       err;
`endif

  int passed = 0;
  int total  = 0;

  shift_counter_multi #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .dir   (dir),
    .mode  (mode),
    .count (count),
    .pos   (pos),
`ifdef SHIFT_COUNTER_MULTI_ERRCHK_EN
    .err   (err),
`endif
    .wrap  (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic       dir;
    logic [1:0] mode;
    logic [7:0] cnt;
    logic [3:0] pos;
    logic       wrap;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic e, input logic d, input logic [1:0] m,
                     input logic [7:0] c, input logic [3:0] p, input logic w);
    vec_t v;
    v = '{r, e, d, m, c, p, w};
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic step(input logic r, input logic e, input logic d, input logic [1:0] m);
    reset = r; en = e; dir = d; mode = m;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; dir = 1'b0; mode = 2'b00;

    // reset, ring up one full lap, hold
    add(1,0,0,2'b00, 8'h01, 0, 0);
    add(0,1,0,2'b00, 8'h02, 1, 0);
    add(0,1,0,2'b00, 8'h04, 2, 0);
    add(0,1,0,2'b00, 8'h08, 3, 0);
    add(0,1,0,2'b00, 8'h10, 4, 0);
    add(0,1,0,2'b00, 8'h20, 5, 0);
    add(0,1,0,2'b00, 8'h40, 6, 0);
    add(0,1,0,2'b00, 8'h80, 7, 0);
    add(0,1,0,2'b00, 8'h01, 0, 1);
    add(0,0,0,2'b00, 8'h01, 0, 0);
    // ring down one lap
    add(0,1,1,2'b00, 8'h80, 7, 0);
    add(0,1,1,2'b00, 8'h40, 6, 0);
    add(0,1,1,2'b00, 8'h20, 5, 0);
    add(0,1,1,2'b00, 8'h10, 4, 0);
    add(0,1,1,2'b00, 8'h08, 3, 0);
    add(0,1,1,2'b00, 8'h04, 2, 0);
    add(0,1,1,2'b00, 8'h02, 1, 0);
    add(0,1,1,2'b00, 8'h01, 0, 1);
    // dir change mid-sequence
    add(0,1,0,2'b00, 8'h02, 1, 0);
    add(0,1,1,2'b00, 8'h01, 0, 1);
    // Johnson: reload then 16 steps up, then two down, then hold
    add(0,1,0,2'b01, 8'h00, 0, 0);
    add(0,1,0,2'b01, 8'h01, 1, 0);
    add(0,1,0,2'b01, 8'h03, 2, 0);
    add(0,1,0,2'b01, 8'h07, 3, 0);
    add(0,1,0,2'b01, 8'h0F, 4, 0);
    add(0,1,0,2'b01, 8'h1F, 5, 0);
    add(0,1,0,2'b01, 8'h3F, 6, 0);
    add(0,1,0,2'b01, 8'h7F, 7, 0);
    add(0,1,0,2'b01, 8'hFF, 8, 0);
    add(0,1,0,2'b01, 8'hFE, 9, 0);
    add(0,1,0,2'b01, 8'hFC, 10, 0);
    add(0,1,0,2'b01, 8'hF8, 11, 0);
    add(0,1,0,2'b01, 8'hF0, 12, 0);
    add(0,1,0,2'b01, 8'hE0, 13, 0);
    add(0,1,0,2'b01, 8'hC0, 14, 0);
    add(0,1,0,2'b01, 8'h80, 15, 0);
    add(0,1,0,2'b01, 8'h00, 0, 1);
    add(0,1,1,2'b01, 8'h80, 15, 0);
    add(0,1,1,2'b01, 8'hC0, 14, 0);
    add(0,0,1,2'b01, 8'hC0, 14, 0);
    // ring to pos 5, switch to Johnson with en high, then reset into bounce
    add(0,1,0,2'b00, 8'h01, 0, 0);
    add(0,1,0,2'b00, 8'h02, 1, 0);
    add(0,1,0,2'b00, 8'h04, 2, 0);
    add(0,1,0,2'b00, 8'h08, 3, 0);
    add(0,1,0,2'b00, 8'h10, 4, 0);
    add(0,1,0,2'b00, 8'h20, 5, 0);
    add(0,1,0,2'b01, 8'h00, 0, 0);
    add(0,1,0,2'b01, 8'h01, 1, 0);
    add(0,1,0,2'b01, 8'h03, 2, 0);
    add(1,1,0,2'b10, 8'h01, 0, 0);
    add(0,1,1,2'b10, 8'h02, 1, 0);
    // reserved mode behaves as ring
    add(0,1,0,2'b11, 8'h01, 0, 0);
    add(0,1,0,2'b11, 8'h02, 1, 0);
    add(0,1,1,2'b11, 8'h01, 0, 1);

    @(negedge clk);
    foreach (vq[i]) begin
      step(vq[i].rst, vq[i].en, vq[i].dir, vq[i].mode);
      chk($sformatf("v%0d count", i), 32'(count), 32'(vq[i].cnt));
      chk($sformatf("v%0d pos",   i), 32'(pos),   32'(vq[i].pos));
      chk($sformatf("v%0d wrap",  i), 32'(wrap),  32'(vq[i].wrap));
    end

    // bounce: two full periods with dir toggled randomly
    step(0, 1, 0, 2'b10);
    chk("bounce reload count", 32'(count), 32'h01);
    chk("bounce reload pos",   32'(pos),   32'd0);
    for (int k = 1; k <= 28; k++) begin
      int m, p;
      m = k % 14;
      p = (m <= 7) ? m : 14 - m;
      step(0, 1, 1'($urandom_range(0, 1)), 2'b10);
      chk($sformatf("bounce k%0d count", k), 32'(count), 32'h1 << p);
      chk($sformatf("bounce k%0d pos",   k), 32'(pos),   32'(p));
      chk($sformatf("bounce k%0d wrap",  k), 32'(wrap),  32'(m == 0));
    end

`ifdef SHIFT_COUNTER_MULTI_ERRCHK_EN
    step(1, 0, 0, 2'b00);
    chk("err after reset", 32'(err), 32'd0);
    step(0, 1, 0, 2'b00);
    step(0, 1, 0, 2'b00);
    chk("err legal stepping", 32'(err), 32'd0);
    force dut.count_q = 8'b0000_0101;
    #1 release dut.count_q;
    step(0, 1, 0, 2'b00);
    chk("errchk count", 32'(count), 32'h01);
    chk("errchk pos",   32'(pos),   32'd0);
    chk("errchk wrap",  32'(wrap),  32'd0);
    chk("errchk err",   32'(err),   32'd1);
    for (int k = 0; k < 3; k++) step(0, 1, 0, 2'b00);
    chk("err sticky count", 32'(count), 32'h08);
    chk("err sticky",       32'(err),   32'd1);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 1, 2'b00);
      chk("hold count", 32'(count), 32'h08);
      chk("hold pos",   32'(pos),   32'd3);
      chk("hold wrap",  32'(wrap),  32'd0);
      chk("hold err",   32'(err),   32'd1);
    end
    step(1, 0, 0, 2'b00);
    chk("err cleared", 32'(err), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
